// File: rtl/s_mem_wb_pipe.sv
// MEM->WB stage register: 2-entry skid buffer, flush, bubble masking,
// $zero write suppression and a saturating stall counter.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   flush           squash both held entries at the next edge
//   in_valid/ready  MEM-side handshake (in_ready is a register output)
//   in_ctrl_wb      WB control bundle from MEM
//   in_read_data    data-memory read value
//   in_alu_result   ALU result forwarded through MEM
//   in_write_reg    destination register index
//   out_valid/ready WB-side handshake
//   out_ctrl_wb     WB control, zero while out_valid=0
//   out_read_data   held read data
//   out_alu_result  held ALU result
//   out_write_reg   held destination index
//   stall_cnt       saturating count of out_valid && !out_ready cycles
module s_mem_wb_pipe #(
  parameter int DATA_W        = 32,
  parameter int REG_W         = 5,
  parameter int CTRL_W        = 2,
  parameter int REGWRITE_BIT  = 1,
  parameter int ZERO_SUPPRESS = 1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl_wb,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [REG_W-1:0]  in_write_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl_wb,
  output logic [DATA_W-1:0] out_read_data,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [REG_W-1:0]  out_write_reg,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_rd;
  logic [DATA_W-1:0] m_alu;
  logic [REG_W-1:0]  m_wr;

  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_rd;
  logic [DATA_W-1:0] s_alu;
  logic [REG_W-1:0]  s_wr;

  logic              accept;
  logic              consume;
  logic [CTRL_W-1:0] cap_ctrl;

  // Ready depends only on skid occupancy, so no comb path from out_ready.
  assign in_ready = !s_valid;
  assign accept   = in_valid && in_ready;
  assign consume  = m_valid && out_ready;

  // A write to $zero is never architecturally visible; drop it here.
  always_comb begin
    cap_ctrl = in_ctrl_wb;
    if (ZERO_SUPPRESS != 0 && in_write_reg == '0)
      cap_ctrl[REGWRITE_BIT] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid   <= 1'b0;
      m_ctrl    <= '0;
      m_rd      <= '0;
      m_alu     <= '0;
      m_wr      <= '0;
      s_valid   <= 1'b0;
      s_ctrl    <= '0;
      s_rd      <= '0;
      s_alu     <= '0;
      s_wr      <= '0;
      stall_cnt <= '0;
    end else begin
      if (m_valid && !out_ready && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;

      if (flush) begin
        m_valid <= 1'b0;
        s_valid <= 1'b0;
      end else if (!m_valid || consume) begin
        if (s_valid) begin
          m_valid <= 1'b1;
          m_ctrl  <= s_ctrl;
          m_rd    <= s_rd;
          m_alu   <= s_alu;
          m_wr    <= s_wr;
          s_valid <= accept;
          if (accept) begin
            s_ctrl <= cap_ctrl;
            s_rd   <= in_read_data;
            s_alu  <= in_alu_result;
            s_wr   <= in_write_reg;
          end
        end else begin
          m_valid <= accept;
          if (accept) begin
            m_ctrl <= cap_ctrl;
            m_rd   <= in_read_data;
            m_alu  <= in_alu_result;
            m_wr   <= in_write_reg;
          end
        end
      end else if (accept) begin
        s_valid <= 1'b1;
        s_ctrl  <= cap_ctrl;
        s_rd    <= in_read_data;
        s_alu   <= in_alu_result;
        s_wr    <= in_write_reg;
      end
    end
  end

  assign out_valid      = m_valid;
  assign out_ctrl_wb    = m_valid ? m_ctrl : '0;
  assign out_read_data  = m_rd;
  assign out_alu_result = m_alu;
  assign out_write_reg  = m_wr;

endmodule

// File: tb/tb_s_mem_wb_pipe.sv
// Bench for s_mem_wb_pipe: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_s_mem_wb_pipe;

  localparam int CNT_W = 3;

  typedef struct {
    logic [1:0]  ctrl;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_ctrl_wb = '0;
  logic [31:0] in_read_data = '0;
  logic [31:0] in_alu_result = '0;
  logic [4:0]  in_write_reg = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_ctrl_wb;
  logic [31:0] out_read_data;
  logic [31:0] out_alu_result;
  logic [4:0]  out_write_reg;
  logic [CNT_W-1:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  word_t q[$];
  int    m_cnt = 0;

  always #5 clk = ~clk;

  s_mem_wb_pipe #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl_wb(in_ctrl_wb),
    .in_read_data(in_read_data),
    .in_alu_result(in_alu_result),
    .in_write_reg(in_write_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl_wb(out_ctrl_wb),
    .out_read_data(out_read_data),
    .out_alu_result(out_alu_result),
    .out_write_reg(out_write_reg),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic word_t mk(logic [1:0] c, logic [31:0] d,
                               logic [31:0] a, logic [4:0] r);
    word_t w;
    w.ctrl = c; w.rd = d; w.alu = a; w.wr = r;
    return w;
  endfunction

  function automatic word_t rnd_word();
    logic [4:0] r;
    r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    return mk(2'($urandom), $urandom, $urandom, r);
  endfunction

  // Register-write to x0 is dropped on capture.
  function automatic word_t xform(word_t w);
    word_t o = w;
    if (o.wr == 5'd0) o.ctrl[1] = 1'b0;
    return o;
  endfunction

  // Model: at most two words in FIFO order; ready when fewer than two.
  task automatic model_edge();
    bit acc, con;
    acc = in_valid && (q.size() < 2);
    con = (q.size() > 0) && out_ready;
    if (q.size() > 0 && !out_ready && m_cnt < (1 << CNT_W) - 1)
      m_cnt++;
    if (flush) begin
      q.delete();
    end else begin
      if (con) void'(q.pop_front());
      if (acc)
        q.push_back(xform(mk(in_ctrl_wb, in_read_data,
                             in_alu_result, in_write_reg)));
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("ctrl_wb", 32'(out_ctrl_wb),
        (q.size() > 0) ? 32'(q[0].ctrl) : 32'd0);
    if (q.size() > 0) begin
      chk("alu", out_alu_result, q[0].alu);
      chk("rdata", out_read_data, q[0].rd);
      chk("wreg", 32'(out_write_reg), 32'(q[0].wr));
    end
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
  endtask

  task automatic step(input logic v, input word_t w,
                      input logic ordy, input logic fl);
    in_valid      = v;
    in_ctrl_wb    = w.ctrl;
    in_read_data  = w.rd;
    in_alu_result = w.alu;
    in_write_reg  = w.wr;
    out_ready     = ordy;
    flush         = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // Called at a negedge; asserts rst between edges.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    q.delete();
    m_cnt = 0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_ctrl", 32'(out_ctrl_wb), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
  endtask

  word_t idle, wa, wb, wc;

  initial begin
    idle = mk(2'b00, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    chk("init_valid", 32'(out_valid), 32'd0);
    chk("init_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    compare_all();

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, mk(2'b11, 32'(i * 3), 32'(i), 5'd7),
           1'b1, 1'b0);
      chk("stream_alu", out_alu_result, 32'(i));
      chk("stream_rdy", 32'(in_ready), 32'd1);
    end
    step(1'b0, idle, 1'b1, 1'b0);

    // Backpressure: A held, B in skid
    wa = mk(2'b11, 32'hA0, 32'hAA, 5'd3);
    wb = mk(2'b10, 32'hB0, 32'hBB, 5'd4);
    step(1'b1, wa, 1'b0, 1'b0);
    step(1'b1, wb, 1'b0, 1'b0);
    chk("bp_ready", 32'(in_ready), 32'd0);
    chk("bp_head", out_alu_result, 32'hAA);
    step(1'b0, idle, 1'b0, 1'b0);
    chk("bp_stall", 32'(stall_cnt), 32'd2);
    step(1'b0, idle, 1'b1, 1'b0);
    chk("bp_second", out_alu_result, 32'hBB);
    step(1'b0, idle, 1'b1, 1'b0);
    do_reset();

    // Flush with M and S full and C presented
    wc = mk(2'b11, 32'hC0, 32'hCC, 5'd5);
    step(1'b1, wa, 1'b0, 1'b0);
    step(1'b1, wb, 1'b0, 1'b0);
    step(1'b1, wc, 1'b1, 1'b1);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    chk("fl_ctrl", 32'(out_ctrl_wb), 32'd0);
    step(1'b0, idle, 1'b1, 1'b0);
    chk("fl_noC", 32'(out_valid), 32'd0);

    // $zero write suppression
    step(1'b1, mk(2'b11, 32'h1, 32'h2, 5'd0), 1'b1, 1'b0);
    chk("zero_ctrl", 32'(out_ctrl_wb), 32'd1);
    step(1'b1, mk(2'b11, 32'h1, 32'h2, 5'd5), 1'b1, 1'b0);
    chk("nz_ctrl", 32'(out_ctrl_wb), 32'd3);
    step(1'b0, idle, 1'b1, 1'b0);

    // Async reset in a stall with both entries full
    step(1'b1, wa, 1'b0, 1'b0);
    step(1'b1, wb, 1'b0, 1'b0);
    step(1'b0, idle, 1'b0, 1'b0);
    do_reset();

    // Counter saturation
    step(1'b1, wa, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b0, idle, 1'b0, 1'b0);
    chk("sat_cnt", 32'(stall_cnt), 32'd7);
    do_reset();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0)
        do_reset();
      else
        step($urandom_range(0, 9) < 7, rnd_word(),
             $urandom_range(0, 9) < 6,
             $urandom_range(0, 49) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
